// File: rtl/systolic_skew_feeder_if.sv
// rtl/systolic_skew_feeder_if.sv - tile load, stream and completion signals of the skew feeder
interface systolic_skew_feeder_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 8,
    parameter int ADDR_W = 5
);
    logic                    en;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_act;
    logic [DATA_W-1:0]       wr_wgt;
    logic                    start;
    logic                    cluster_done;
    logic [LANES*DATA_W-1:0] activations;
    logic [LANES*DATA_W-1:0] weights;
    logic [LANES-1:0]        done;
    logic                    busy;
    logic                    complete;

    modport master (
        output en, wr_en, wr_addr, wr_act, wr_wgt, start, cluster_done,
        input  activations, weights, done, busy, complete
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_act, wr_wgt, start, cluster_done,
        output activations, weights, done, busy, complete
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - buffers one tile and streams it diagonally into the systolic cluster
module systolic_skew_feeder #(
    parameter int DATA_W = 16,
    parameter int LANES  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    systolic_skew_feeder_if.slave bus
);
    localparam int NUM_ELEMS = LANES * DEPTH;
    localparam int STEP_W    = $clog2(LANES + DEPTH + 1);
    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(LANES - 1 + DEPTH);
    localparam logic [STEP_W-1:0] DEPTH_C    = STEP_W'(DEPTH);
    localparam logic [ADDR_W:0]   ELEM_LIMIT = (ADDR_W + 1)'(NUM_ELEMS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [LANES*DATA_W-1:0] act_q, act_d;
    logic [LANES*DATA_W-1:0] wgt_q, wgt_d;
    logic [LANES-1:0]        done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    complete_q, complete_d;

    logic [DATA_W-1:0]       act_mem_q [NUM_ELEMS];
    logic [DATA_W-1:0]       wgt_mem_q [NUM_ELEMS];
    logic                    mem_we;
    logic [LANES*DATA_W-1:0] feed_act;
    logic [LANES*DATA_W-1:0] feed_wgt;
    logic [LANES-1:0]        done_hit;

    // The tile buffer only changes while idle, so a running stream never sees a torn tile.
    assign mem_we = bus.en && (state_q == S_IDLE) && bus.wr_en
                    && ({1'b0, bus.wr_addr} < ELEM_LIMIT);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            act_mem_q[bus.wr_addr] <= bus.wr_act;
            wgt_mem_q[bus.wr_addr] <= bus.wr_wgt;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [STEP_W-1:0] FIRST   = STEP_W'(k);
        localparam logic [STEP_W-1:0] DONE_AT = STEP_W'(k + DEPTH);
        localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(k * DEPTH);

        logic [STEP_W:0]   diff;
        logic              in_window;
        logic [ADDR_W-1:0] rd_addr;

        // Lane k lags lane 0 by k steps; a borrow out of the subtraction means "not yet".
        assign diff      = {1'b0, step_q} - {1'b0, FIRST};
        assign in_window = !diff[STEP_W] && (diff[STEP_W-1:0] < DEPTH_C);
        assign rd_addr   = BASE + ADDR_W'(diff[STEP_W-1:0]);

        assign feed_act[k*DATA_W +: DATA_W] = in_window ? act_mem_q[rd_addr] : '0;
        assign feed_wgt[k*DATA_W +: DATA_W] = in_window ? wgt_mem_q[rd_addr] : '0;
        assign done_hit[k] = (step_q == DONE_AT);
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        act_d      = act_q;
        wgt_d      = wgt_q;
        done_d     = done_q;
        busy_d     = busy_q;
        complete_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FEED;
                    step_d  = '0;
                    done_d  = '0;
                    busy_d  = 1'b1;
                    act_d   = '0;
                    wgt_d   = '0;
                end
            end
            S_FEED: begin
                act_d  = feed_act;
                wgt_d  = feed_wgt;
                done_d = done_q | done_hit;
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    state_d = S_DRAIN;
                    act_d   = '0;
                    wgt_d   = '0;
                end
            end
            S_DRAIN: begin
                act_d  = '0;
                wgt_d  = '0;
                done_d = '1;
                if (bus.cluster_done) begin
                    state_d    = S_IDLE;
                    busy_d     = 1'b0;
                    complete_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            act_q      <= '0;
            wgt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else if (bus.en) begin
            state_q    <= state_d;
            step_q     <= step_d;
            act_q      <= act_d;
            wgt_q      <= wgt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
        end
    end

    assign bus.activations = act_q;
    assign bus.weights     = wgt_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.complete    = complete_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed vector bench for systolic_skew_feeder
module tb_systolic_skew_feeder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    systolic_skew_feeder_if #(.DATA_W(16), .LANES(8), .ADDR_W(5)) bus ();

    systolic_skew_feeder #(.DATA_W(16), .LANES(8), .DEPTH(4), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        cd;
        logic [15:0] lane0;
        logic [15:0] lane7;
        logic [7:0]  done;
        logic        busy;
        logic        complete;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected bus after edge e of a run over the reference tile: lane k holds element e-1-k.
    function automatic logic [127:0] model_bus(input int e, input logic [15:0] base);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            int j;
            j = e - 1 - k;
            if (j >= 0 && j < 4) r[k*16 +: 16] = base + 16'(k * 4 + j);
        end
        return r;
    endfunction

    task automatic start_run();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic finish_drain();
        bus.cluster_done = 1'b1;
        step();
        chk("drain_complete", 128'(bus.complete), 128'd1);
        bus.cluster_done = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        bus.en           = 1'b1;
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_act       = '0;
        bus.wr_wgt       = '0;
        bus.start        = 1'b0;
        bus.cluster_done = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 16'd0,  16'd0,  8'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 16'd1,  16'd0,  8'h00, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 16'd2,  16'd0,  8'h00, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 16'd3,  16'd0,  8'h00, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 16'd4,  16'd0,  8'h00, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 16'd0,  16'd0,  8'h01, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'd0,  16'd0,  8'h03, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 16'd0,  16'd0,  8'h07, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 16'd0,  16'd29, 8'h0F, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'd0,  16'd30, 8'h1F, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 16'd0,  16'd31, 8'h3F, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 16'd0,  16'd32, 8'h7F, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 16'd0,  16'd0,  8'hFF, 1'b1, 1'b0};
        for (int i = 13; i < 18; i++) tbl[i] = '{1'b0, 1'b0, 16'd0, 16'd0, 8'hFF, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 16'd0,  16'd0,  8'hFF, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 16'd0,  16'd0,  8'hFF, 1'b0, 1'b0};

        #12;
        chk("reset_act",  bus.activations, 128'd0);
        chk("reset_wgt",  bus.weights, 128'd0);
        chk("reset_done", 128'(bus.done), 128'd0);
        chk("reset_busy", 128'(bus.busy), 128'd0);
        chk("reset_cmpl", 128'(bus.complete), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 5'(a);
            bus.wr_act  = 16'(a + 1);
            bus.wr_wgt  = 16'(16'h100 + a);
            step();
        end
        bus.wr_en = 1'b0;

        // Main tile, row i is checked after edge i (edge 0 is the start edge).
        for (int i = 0; i < 20; i++) begin
            bus.start        = tbl[i].start;
            bus.cluster_done = tbl[i].cd;
            step();
            chk($sformatf("row%0d_lane0", i), 128'(bus.activations[15:0]), 128'(tbl[i].lane0));
            chk($sformatf("row%0d_lane7", i), 128'(bus.activations[127:112]), 128'(tbl[i].lane7));
            chk($sformatf("row%0d_done", i), 128'(bus.done), 128'(tbl[i].done));
            chk($sformatf("row%0d_busy", i), 128'(bus.busy), 128'(tbl[i].busy));
            chk($sformatf("row%0d_cmpl", i), 128'(bus.complete), 128'(tbl[i].complete));
            chk($sformatf("row%0d_act", i), bus.activations, model_bus(i, 16'd1));
            chk($sformatf("row%0d_wgt", i), bus.weights, model_bus(i, 16'h100));
        end
        bus.start        = 1'b0;
        bus.cluster_done = 1'b0;

        // Enable drop after edge 6 freezes everything and resumes in place.
        start_run();
        repeat (6) step();
        chk("freeze_pre_lane2", 128'(bus.activations[47:32]), 128'd12);
        bus.en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("freeze%0d_lane2", c), 128'(bus.activations[47:32]), 128'd12);
            chk($sformatf("freeze%0d_done", c), 128'(bus.done), 128'h03);
            chk($sformatf("freeze%0d_act", c), bus.activations, model_bus(6, 16'd1));
        end
        bus.en = 1'b1;
        step();
        chk("resume_lane2", 128'(bus.activations[47:32]), 128'd0);
        chk("resume_lane3", 128'(bus.activations[63:48]), 128'd16);
        chk("resume_done",  128'(bus.done), 128'h07);
        for (int e = 8; e <= 12; e++) begin
            step();
            chk($sformatf("resume_e%0d_act", e), bus.activations, model_bus(e, 16'd1));
        end
        chk("resume_done_all", 128'(bus.done), 128'hFF);
        finish_drain();

        // cluster_done during FEED is ignored; held into DRAIN it completes on the first DRAIN edge.
        bus.cluster_done = 1'b1;
        start_run();
        repeat (11) step();
        chk("cdfeed_e11_done", 128'(bus.done), 128'h7F);
        chk("cdfeed_e11_busy", 128'(bus.busy), 128'd1);
        step();
        chk("cdfeed_e12_done", 128'(bus.done), 128'hFF);
        chk("cdfeed_e12_cmpl", 128'(bus.complete), 128'd0);
        step();
        chk("cdfeed_e13_cmpl", 128'(bus.complete), 128'd1);
        chk("cdfeed_e13_busy", 128'(bus.busy), 128'd0);
        bus.cluster_done = 1'b0;
        step();
        chk("cdfeed_pulse_end", 128'(bus.complete), 128'd0);
        chk("cdfeed_done_held", 128'(bus.done), 128'hFF);

        // Asynchronous reset in the middle of a stream.
        start_run();
        repeat (6) step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_act",  bus.activations, 128'd0);
        chk("arst_wgt",  bus.weights, 128'd0);
        chk("arst_done", 128'(bus.done), 128'd0);
        chk("arst_busy", 128'(bus.busy), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_idle_busy", 128'(bus.busy), 128'd0);
        start_run();
        step();
        chk("replay_lane0", 128'(bus.activations[15:0]), 128'd1);
        chk("replay_lane1", 128'(bus.activations[31:16]), 128'd0);
        repeat (11) step();
        finish_drain();

        // start and a write during FEED are both ignored.
        start_run();
        repeat (2) step();
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd0;
        bus.wr_act  = 16'hBEEF;
        bus.wr_wgt  = 16'hBEEF;
        step();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk("feedwr_lane0", 128'(bus.activations[15:0]), 128'd3);
        chk("feedwr_done",  128'(bus.done), 128'h00);
        for (int e = 4; e <= 12; e++) begin
            step();
            chk($sformatf("feedwr_e%0d_act", e), bus.activations, model_bus(e, 16'd1));
        end
        chk("feedwr_done_all", 128'(bus.done), 128'hFF);
        finish_drain();
        start_run();
        step();
        chk("feedwr_next_act0", 128'(bus.activations[15:0]), 128'd1);
        chk("feedwr_next_wgt0", 128'(bus.weights[15:0]), 128'h100);
        repeat (11) step();
        finish_drain();

        // A write on the start edge lands before the first element is read.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd0;
        bus.wr_act  = 16'h0055;
        bus.wr_wgt  = 16'h0077;
        bus.start   = 1'b1;
        step();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        chk("wrstart_busy", 128'(bus.busy), 128'd1);
        step();
        chk("wrstart_act0", 128'(bus.activations[15:0]), 128'h55);
        chk("wrstart_wgt0", 128'(bus.weights[15:0]), 128'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Upstream stage of pe_8x8_cluster. Buffers one tile of activations and weights: 8 lanes × DEPTH elements each. On start it streams the tile into the cluster in the diagonal (skewed) order the systolic array needs: lane k is delayed k cycles behind lane 0. It raises a per-lane done after each lane's last element, then waits for the cluster's final done before reporting completion.

Parameters:
DATA_W, 16, width of one activation/weight element
LANES, 8, number of array rows/columns fed (lanes)
DEPTH, 4, elements streamed per lane
ADDR_W, 5, buffer address width; must satisfy 2^ADDR_W >= LANES*DEPTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; when low, all state and outputs hold
wr_en  input  1  buffer write strobe
wr_addr  input  ADDR_W  buffer address; lane k element j lives at k*DEPTH+j
wr_act  input  DATA_W  activation write data
wr_wgt  input  DATA_W  weight write data
start  input  1  begin streaming the buffered tile
cluster_done  input  1  final done from cluster (output_dones MSB)
activations  output  LANES*DATA_W  lane k on bits [k*DATA_W +: DATA_W]
weights  output  LANES*DATA_W  same lane packing as activations
done  output  LANES  per-lane end-of-stream flags, sticky
busy  output  1  high in FEED and DRAIN
complete  output  1  one-cycle pulse on return to IDLE after cluster_done

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, step=0.
  - activations=0, weights=0, done=0, busy=0, complete=0.
  - Buffer contents are don't-care.
  - Reset mid-stream aborts immediately with no further output.
- en=0: every register holds, including buffer writes (ignored). Outputs hold their last values. Resuming continues exactly where it stopped.
- Buffer writes: accepted only when en=1 and state=IDLE. Otherwise ignored.
  - Addresses >= LANES*DEPTH are ignored.
  - A write and a start in the same cycle: the write lands and start is accepted. The written value is visible to the stream.
- All outputs are registered. Cycle numbering below counts rising edges with en=1.
- FSM:
  - IDLE: start=1 → FEED. On the same edge: step=0, done=0, busy=1.
  - FEED: at step s, lane k drives element j=s-k if 0<=j<DEPTH, otherwise 0 (bubble). Activations and weights are driven identically.
    - done[k] is set on the edge where s==k+DEPTH and stays set.
    - step increments every edge.
    - On the edge where s==LANES-1+DEPTH: done[LANES-1] rises, all data is 0, and the FSM moves to DRAIN.
  - DRAIN: data=0, done all ones. cluster_done=1 → IDLE, complete=1 for one cycle, busy=0. done stays all ones until the next start.
- Latency:
  - Lane k element j appears after edge 1+k+j counted from the start edge.
  - done[k] appears after edge 1+k+DEPTH.
  - FEED lasts LANES+DEPTH edges (12 with defaults).
- Ignored inputs:
  - start is ignored in FEED and DRAIN.
  - cluster_done is ignored outside DRAIN.
  - A cluster_done held high on entry to DRAIN completes on the first DRAIN edge.
- Counters: step width is ceil(log2(LANES+DEPTH+1)) bits. No wrap within a run.

Test Plan:
- Load act[a]=a+1 and wgt[a]=0x100+a for a=0..31, then start.
  - Lane0 shows 1,2,3,4 after edges 1–4.
  - Lane7 shows 29,30,31,32 after edges 8–11; weights show 0x11C..0x11F.
  - All other lane/cycle slots are 0.
  - done[0] after edge 5; done[7] after edge 12; busy=1 throughout.
- After FEED, hold cluster_done=0 for 5 cycles: stay in DRAIN with data 0 and done=0xFF. Then pulse cluster_done: complete=1 for exactly one cycle, busy=0, done stays 0xFF.
- Drop en for 3 cycles after edge 6: outputs frozen (lane2 holds element 3=12). After en returns, lane2 shows 0 and done[2] rises on the next edge; the total sequence is otherwise unchanged.
- Assert rst_n=0 asynchronously at edge 7: all outputs 0 immediately, state IDLE. A new start replays from element 0.
- Assert start and wr_en (addr 0, value 0xBEEF) during FEED: no restart, and that run's stream is unaffected. After returning to IDLE, a new start shows lane0 first element = 1, proving the write was ignored.
- Assert cluster_done during FEED: ignored, FEED completes its full 12 edges. Holding cluster_done high into DRAIN gives complete after the first DRAIN edge.
